hex_scan_ctrl: RTL and testbench



---
 rtl/hex_scan_ctrl_pkg.sv | 26 ++
 rtl/hex_scan_tick.sv | 52 +++++
 rtl/hex_scan_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scan_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_ctrl_pkg                                         |
// | Purpose  : Shared types and defaults for the multiplexed 7-segment   |
// |            scan controller and its prescaler.                        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package hex_scan_ctrl_pkg;

  // Controller state: all digits dark, or multiplexing the active result.
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_t;

  localparam int c_num_digits_default   = 4;
  localparam int c_scan_div_default     = 1000;
  localparam int c_blink_frames_default = 32;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_tick                                             |
// | Purpose  : Digit-hold prescaler. Counts 0..SCAN_DIV-1 while enabled  |
// |            and flags the terminal count; restart forces count 0.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hex_scan_tick
  import hex_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = c_scan_div_default
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick,
  output logic tick_ahead
);

  localparam int            CW     = clog2_min1(SCAN_DIV);
  localparam logic [CW-1:0] c_last = CW'(SCAN_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  // Next count: restart wins, otherwise wrap at the terminal count.
  always_comb begin
    w_cnt_next = r_cnt;
    if (restart) begin
      w_cnt_next = '0;
    end else if (en) begin
      w_cnt_next = (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  // tick marks the last cycle of a digit slot; tick_ahead predicts it one
  // edge early so the parent can register slot-aligned outputs.
  assign tick       = en && (r_cnt == c_last);
  assign tick_ahead = (w_cnt_next == c_last);

endmodule
`default_nettype wire

// File: rtl/hex_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hex_scan_ctrl                                             |
// | Purpose  : Time-multiplexed 7-segment scan controller with frame-    |
// |            aligned result updates, leading-zero blanking and a       |
// |            blinking error pattern. Drives a shared HEXDRV decoder.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = c_num_digits_default,
  parameter int SCAN_DIV     = c_scan_div_default,
  parameter int BLINK_FRAMES = c_blink_frames_default
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    err_in,
  input  logic                    clear,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   digit_sel_n,
  output logic [3:0]              nibble,
  output logic                    error,
  output logic                    off_bit,
  output logic                    frame_done
);

  localparam int            IW           = clog2_min1(NUM_DIGITS);
  localparam int            BW           = clog2_min1(2 * BLINK_FRAMES);
  localparam logic [IW-1:0] c_last_idx   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] c_blink_half = BW'(BLINK_FRAMES);
  localparam logic [BW-1:0] c_blink_last = BW'(2 * BLINK_FRAMES - 1);

  scan_state_t             r_state;
  logic [IW-1:0]           r_idx;
  logic [BW-1:0]           r_blink;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic                    r_act_err;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic                    r_pend_err;
  logic                    r_pend_valid;

  scan_state_t             w_state_next;
  logic [IW-1:0]           w_idx_next;
  logic [BW-1:0]           w_blink_next;
  logic [4*NUM_DIGITS-1:0] w_act_data_next;
  logic                    w_act_err_next;
  logic [4*NUM_DIGITS-1:0] w_pend_data_next;
  logic                    w_pend_err_next;
  logic                    w_pend_valid_next;
  logic                    w_ready_next;

  logic [NUM_DIGITS-1:0]   w_sel_n_next;
  logic [3:0]              w_nibble_next;
  logic                    w_error_next;
  logic                    w_off_next;
  logic                    w_frame_done_next;
  logic [IW-1:0]           w_msd;

  logic w_tick;
  logic w_tick_ahead;
  logic w_scan_en;
  logic w_scan_restart;

  // The prescaler idles at zero while blank, so the first slot after a
  // load and the slot after a clear both start from a fresh count.
  assign w_scan_en      = (r_state == ST_SCAN);
  assign w_scan_restart = (r_state == ST_BLANK) || clear;

  hex_scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (w_scan_en),
    .restart    (w_scan_restart),
    .tick       (w_tick),
    .tick_ahead (w_tick_ahead)
  );

  // Next-state logic: load/clear handling, digit advance and frame-boundary
  // promotion of the pending result.
  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_blink_next      = r_blink;
    w_act_data_next   = r_act_data;
    w_act_err_next    = r_act_err;
    w_pend_data_next  = r_pend_data;
    w_pend_err_next   = r_pend_err;
    w_pend_valid_next = r_pend_valid;
    w_ready_next      = ready;

    case (r_state)
      ST_BLANK: begin
        if (load) begin
          w_state_next      = ST_SCAN;
          w_act_data_next   = data_in;
          w_act_err_next    = err_in;
          w_idx_next        = '0;
          w_blink_next      = '0;
          w_pend_valid_next = 1'b0;
          w_ready_next      = 1'b1;
        end
      end
      ST_SCAN: begin
        if (clear) begin
          w_state_next      = ST_BLANK;
          w_idx_next        = '0;
          w_blink_next      = '0;
          w_pend_valid_next = 1'b0;
          w_ready_next      = 1'b1;
        end else begin
          if (w_tick) begin
            if (r_idx == c_last_idx) begin
              w_idx_next   = '0;
              w_blink_next = (r_blink == c_blink_last) ? '0 : r_blink + 1'b1;
              if (r_pend_valid) begin
                w_act_data_next   = r_pend_data;
                w_act_err_next    = r_pend_err;
                w_blink_next      = '0;
                w_pend_valid_next = 1'b0;
                w_ready_next      = 1'b1;
              end
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
          // ready is only high with nothing pending, so a capture here can
          // never collide with the promotion above.
          if (load && ready) begin
            w_pend_data_next  = data_in;
            w_pend_err_next   = err_in;
            w_pend_valid_next = 1'b1;
            w_ready_next      = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = ST_BLANK;
      end
    endcase
  end

  // Display values for the slot that starts on the next edge, computed from
  // the next-cycle active registers so outputs switch with digit_sel_n.
  always_comb begin
    w_sel_n_next      = '1;
    w_nibble_next     = 4'h0;
    w_error_next      = 1'b0;
    w_off_next        = 1'b1;
    w_frame_done_next = 1'b0;
    w_msd             = '0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_act_data_next[4*i +: 4] != 4'h0) begin
        w_msd = IW'(i);
      end
    end

    if (w_state_next == ST_SCAN) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (IW'(i) == w_idx_next) begin
          w_sel_n_next[i] = 1'b0;
          w_nibble_next   = w_act_data_next[4*i +: 4];
        end
      end
      if (w_act_err_next) begin
        // Second half of the blink period shows nothing at all.
        w_error_next = (w_blink_next < c_blink_half);
        w_off_next   = (w_blink_next >= c_blink_half);
      end else begin
        w_off_next = (w_idx_next > w_msd);
      end
      w_frame_done_next = w_tick_ahead && (w_idx_next == c_last_idx);
    end
  end

  // FSM state, result registers and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_idx        <= '0;
      r_blink      <= '0;
      r_act_data   <= '0;
      r_act_err    <= 1'b0;
      r_pend_data  <= '0;
      r_pend_err   <= 1'b0;
      r_pend_valid <= 1'b0;
      ready        <= 1'b1;
      digit_sel_n  <= '1;
      nibble       <= 4'h0;
      error        <= 1'b0;
      off_bit      <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_blink      <= w_blink_next;
      r_act_data   <= w_act_data_next;
      r_act_err    <= w_act_err_next;
      r_pend_data  <= w_pend_data_next;
      r_pend_err   <= w_pend_err_next;
      r_pend_valid <= w_pend_valid_next;
      ready        <= w_ready_next;
      digit_sel_n  <= w_sel_n_next;
      nibble       <= w_nibble_next;
      error        <= w_error_next;
      off_bit      <= w_off_next;
      frame_done   <= w_frame_done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hex_scan_ctrl                                          |
// | Purpose  : Self-checking bench for hex_scan_ctrl: directed table,    |
// |            hand sequences and randomized traffic vs a frame model.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_hex_scan_ctrl;

  localparam int N  = 4;
  localparam int S  = 4;
  localparam int BF = 2;
  localparam int FL = N * S;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic [15:0]   data_in;
  logic          err_in;
  logic          clear;
  logic          ready;
  logic [3:0]    digit_sel_n;
  logic [3:0]    nibble;
  logic          error;
  logic          off_bit;
  logic          frame_done;

  hex_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .data_in     (data_in),
    .err_in      (err_in),
    .clear       (clear),
    .ready       (ready),
    .digit_sel_n (digit_sel_n),
    .nibble      (nibble),
    .error       (error),
    .off_bit     (off_bit),
    .frame_done  (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: time since scan start, active/pending results and the
  // frame in which the active result was applied.
  bit          m_scan;
  int          m_t;
  int          m_apply_frame;
  logic [15:0] m_act;
  bit          m_err;
  logic [15:0] m_pend;
  bit          m_pend_err;
  bit          m_pv;

  function automatic void model_reset();
    m_scan = 0; m_t = 0; m_apply_frame = 0; m_pv = 0;
    m_act = '0; m_err = 0; m_pend = '0; m_pend_err = 0;
  endfunction

  function automatic void model_edge(bit ld, logic [15:0] d, bit e, bit clr);
    bit acc;
    bit wrap;
    if (!m_scan) begin
      if (ld) begin
        m_scan = 1; m_t = 0; m_act = d; m_err = e; m_apply_frame = 0; m_pv = 0;
      end
    end else if (clr) begin
      m_scan = 0; m_pv = 0;
    end else begin
      acc  = ld && !m_pv;
      wrap = (m_t % FL) == FL - 1;
      m_t++;
      if (wrap && m_pv) begin
        m_act = m_pend; m_err = m_pend_err; m_apply_frame = m_t / FL; m_pv = 0;
      end
      if (acc) begin
        m_pend = d; m_pend_err = e; m_pv = 1;
      end
    end
  endfunction

  task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic check_model();
    logic [3:0] e_sel;
    logic [3:0] e_nib;
    logic       e_err, e_off, e_rdy, e_fd;
    int         pos, idx, fr, msd;
    bit         bb;
    n_vec++;
    e_sel = 4'hF; e_nib = 4'h0; e_err = 0; e_off = 1; e_rdy = 1; e_fd = 0;
    if (m_scan) begin
      pos = m_t % FL;
      idx = pos / S;
      fr  = m_t / FL;
      bb  = (((fr - m_apply_frame) / BF) % 2) == 1;
      e_sel[idx] = 1'b0;
      e_nib = m_act[idx*4 +: 4];
      msd = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (msd == 0 && m_act[i*4 +: 4] != 4'h0) msd = i;
      end
      if (m_err) begin
        e_err = !bb; e_off = bb;
      end else begin
        e_err = 0; e_off = (idx > msd);
      end
      e_rdy = !m_pv;
      e_fd  = (pos == FL - 1);
    end
    cmp("digit_sel_n", 16'(digit_sel_n), 16'(e_sel));
    if (!(m_scan && m_err)) cmp("nibble", 16'(nibble), 16'(e_nib));
    cmp("error", 16'(error), 16'(e_err));
    cmp("off_bit", 16'(off_bit), 16'(e_off));
    cmp("ready", 16'(ready), 16'(e_rdy));
    cmp("frame_done", 16'(frame_done), 16'(e_fd));
  endtask

  // One clock: drive inputs, advance model on the edge, settle past it.
  task automatic step(input bit ld, input logic [15:0] d, input bit e, input bit clr);
    load = ld; data_in = d; err_in = e; clear = clr;
    @(posedge clk);
    model_edge(ld, d, e, clr);
    #1;
    load = 0; clear = 0;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      step(0, data_in, 0, 0);
      check_model();
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    cmp({tag, ".digit_sel_n"}, 16'(digit_sel_n), 16'hF);
    cmp({tag, ".nibble"}, 16'(nibble), 16'h0);
    cmp({tag, ".error"}, 16'(error), 16'h0);
    cmp({tag, ".off_bit"}, 16'(off_bit), 16'h1);
    cmp({tag, ".ready"}, 16'(ready), 16'h1);
    cmp({tag, ".frame_done"}, 16'(frame_done), 16'h0);
  endtask

  typedef struct {
    bit          ld;
    logic [15:0] d;
    bit          clr;
    logic [3:0]  sel_n;
    logic [3:0]  nib;
    bit          err;
    bit          off;
    bit          rdy;
    bit          fd;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit ld, logic [15:0] d, bit clr, logic [3:0] sel_n,
                              logic [3:0] nib, bit err, bit off, bit rdy, bit fd);
    vec_t v;
    v.ld = ld; v.d = d; v.clr = clr; v.sel_n = sel_n; v.nib = nib;
    v.err = err; v.off = off; v.rdy = rdy; v.fd = fd;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [3:0] sel_c [4];
    logic [3:0] nib_c [4];
    bit         off_c [4];
    logic [31:0] rnd, mask;

    sel_c[0] = 4'hE; sel_c[1] = 4'hD; sel_c[2] = 4'hB; sel_c[3] = 4'h7;
    nib_c[0] = 4'h3; nib_c[1] = 4'hA; nib_c[2] = 4'h0; nib_c[3] = 4'h0;
    off_c[0] = 0;    off_c[1] = 0;    off_c[2] = 1;    off_c[3] = 1;

    // Directed table: one frame of 00A3, then clear/load corner rows.
    add(0, 16'h0000, 0, 4'hF, 4'h0, 0, 1, 1, 0);
    add(1, 16'h00A3, 0, 4'hE, 4'h3, 0, 0, 1, 0);
    for (int c = 1; c < 16; c++)
      add(0, 16'h0000, 0, sel_c[c/4], nib_c[c/4], 0, off_c[c/4], 1, (c == 15));
    add(0, 16'h0000, 0, 4'hE, 4'h3, 0, 0, 1, 0);
    add(1, 16'h1234, 1, 4'hF, 4'h0, 0, 1, 1, 0);
    add(0, 16'h0000, 1, 4'hF, 4'h0, 0, 1, 1, 0);
    add(1, 16'h0000, 0, 4'hE, 4'h0, 0, 0, 1, 0);
    add(0, 16'h0000, 0, 4'hE, 4'h0, 0, 0, 1, 0);
    add(0, 16'h0000, 1, 4'hF, 4'h0, 0, 1, 1, 0);

    rst_n = 0; load = 0; data_in = '0; err_in = 0; clear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    check_reset_values("reset");

    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].d, 0, tbl[i].clr);
      n_vec++;
      cmp($sformatf("tbl%0d.digit_sel_n", i), 16'(digit_sel_n), 16'(tbl[i].sel_n));
      cmp($sformatf("tbl%0d.nibble", i), 16'(nibble), 16'(tbl[i].nib));
      cmp($sformatf("tbl%0d.error", i), 16'(error), 16'(tbl[i].err));
      cmp($sformatf("tbl%0d.off_bit", i), 16'(off_bit), 16'(tbl[i].off));
      cmp($sformatf("tbl%0d.ready", i), 16'(ready), 16'(tbl[i].rdy));
      cmp($sformatf("tbl%0d.frame_done", i), 16'(frame_done), 16'(tbl[i].fd));
    end

    // Idle in blank for a long stretch.
    run(100);

    // Mid-frame reload, then a second load while not ready.
    step(1, 16'h1234, 0, 0); check_model();
    run(6);
    step(1, 16'h5678, 0, 0); check_model();
    run(3);
    step(1, 16'h9999, 0, 0); check_model();
    run(40);

    // Load landing exactly on the frame wrap edge.
    for (int k = 0; k < FL && (m_t % FL) != FL - 1; k++) begin
      step(0, data_in, 0, 0); check_model();
    end
    step(1, 16'h0700, 0, 0); check_model();
    run(40);

    // Error blink over several periods.
    step(0, 16'h0, 0, 1); check_model();
    step(1, 16'h0000, 1, 0); check_model();
    run(4 * BF * FL + 20);

    // load and clear together while scanning.
    step(1, 16'h4321, 0, 1); check_model();
    run(3);

    // Asynchronous reset in the middle of a digit slot.
    step(1, 16'h8765, 0, 0); check_model();
    run(6);
    #2;
    rst_n = 0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    run(5);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      rnd  = $urandom;
      mask = (32'h1 << (4 * $urandom_range(0, 4))) - 32'h1;
      step(($urandom_range(0, 29) == 0), 16'(rnd & mask),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
